// File: rtl/reg_scoreboard_dep_if.sv
// Decode <-> register scoreboard bundle: issue sources/destinations,
// writeback retire and the stall/hazard status returned to decode.
interface reg_scoreboard_dep_if #(
    parameter int NUM_SRC = 4,
    parameter int NUM_DST = 3,
    parameter int ADDR_W  = 3,
    parameter int STRB_W  = 4
);
    logic                        flush;
    logic                        issue_valid;
    logic [NUM_SRC-1:0]          src_needed;
    logic [NUM_SRC*ADDR_W-1:0]   src_addr;
    logic [NUM_SRC*STRB_W-1:0]   src_strb;
    logic [NUM_DST-1:0]          dst_ld;
    logic [NUM_DST*ADDR_W-1:0]   dst_addr;
    logic [NUM_DST*STRB_W-1:0]   dst_strb;
    logic [NUM_DST-1:0]          wb_valid;
    logic [NUM_DST*ADDR_W-1:0]   wb_addr;
    logic [NUM_DST*STRB_W-1:0]   wb_strb;
    logic                        stall;
    logic                        issue_accept;
    logic [NUM_SRC-1:0]          dep_mask;
    logic                        busy;
    logic                        err_underflow;

    modport master (
        output flush, issue_valid, src_needed, src_addr, src_strb,
        output dst_ld, dst_addr, dst_strb, wb_valid, wb_addr, wb_strb,
        input  stall, issue_accept, dep_mask, busy, err_underflow
    );

    modport slave (
        input  flush, issue_valid, src_needed, src_addr, src_strb,
        input  dst_ld, dst_addr, dst_strb, wb_valid, wb_addr, wb_strb,
        output stall, issue_accept, dep_mask, busy, err_underflow
    );
endinterface

// File: rtl/reg_scoreboard_dep.sv
// Per-register, per-byte-lane pending-write scoreboard: stalls issue on
// RAW hazards or counter saturation, retires lanes on writeback.
module reg_scoreboard_dep #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_SRC  = 4,
    parameter int NUM_DST  = 3,
    parameter int STRB_W   = 4,
    parameter int CNT_W    = 2
) (
    input logic                clk,
    input logic                rst_n,
    reg_scoreboard_dep_if.slave sb
);
    localparam int CW = CNT_W + 2;
    localparam logic [CW-1:0] CMAX = CW'((1 << CNT_W) - 1);

    logic [CNT_W-1:0] cnt_q [NUM_REGS][STRB_W];
    logic [CNT_W-1:0] cnt_d [NUM_REGS][STRB_W];
    logic [CW-1:0]    inc   [NUM_REGS][STRB_W];
    logic [CW-1:0]    dec   [NUM_REGS][STRB_W];
    logic [CW-1:0]    sum;
    logic [NUM_SRC-1:0] dep;
    logic full, stall, accept, busy, err_q, err_d;

    // Addresses at or above NUM_REGS never match any r, so they are ignored.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            for (int b = 0; b < STRB_W; b++) begin
                inc[r][b] = '0;
                dec[r][b] = '0;
                for (int d = 0; d < NUM_DST; d++) begin
                    if (sb.dst_ld[d] &&
                        sb.dst_addr[d*ADDR_W +: ADDR_W] == ADDR_W'(r) &&
                        sb.dst_strb[d*STRB_W + b])
                        inc[r][b] = inc[r][b] + CW'(1);
                    if (sb.wb_valid[d] &&
                        sb.wb_addr[d*ADDR_W +: ADDR_W] == ADDR_W'(r) &&
                        sb.wb_strb[d*STRB_W + b])
                        dec[r][b] = dec[r][b] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        dep  = '0;
        full = 1'b0;
        busy = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (cnt_q[r][b] != '0)
                    busy = 1'b1;
                if ({2'b00, cnt_q[r][b]} + inc[r][b] > CMAX)
                    full = 1'b1;
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (sb.src_needed[i] &&
                        sb.src_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(r) &&
                        sb.src_strb[i*STRB_W + b] &&
                        cnt_q[r][b] != '0)
                        dep[i] = 1'b1;
                end
            end
        end
    end

    assign stall  = sb.issue_valid & (|dep | full);
    assign accept = sb.issue_valid & ~stall;

    // A negative lane result shows up as the MSB of the widened sum.
    always_comb begin
        err_d = err_q;
        sum   = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            for (int b = 0; b < STRB_W; b++) begin
                sum = {2'b00, cnt_q[r][b]}
                    + (accept ? inc[r][b] : '0)
                    - dec[r][b];
                if (sb.flush) begin
                    cnt_d[r][b] = '0;
                end else if (sum[CW-1]) begin
                    cnt_d[r][b] = '0;
                    err_d       = 1'b1;
                end else begin
                    cnt_d[r][b] = sum[CNT_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++)
                for (int b = 0; b < STRB_W; b++)
                    cnt_q[r][b] <= '0;
        end else begin
            err_q <= err_d;
            for (int r = 0; r < NUM_REGS; r++)
                for (int b = 0; b < STRB_W; b++)
                    cnt_q[r][b] <= cnt_d[r][b];
        end
    end

    assign sb.stall         = stall;
    assign sb.issue_accept  = accept;
    assign sb.dep_mask      = dep;
    assign sb.busy          = busy;
    assign sb.err_underflow = err_q;
endmodule

// File: tb/tb_reg_scoreboard_dep.sv
// Directed bench for reg_scoreboard_dep: hazards, partial lanes,
// saturation, same-cycle issue/wb, underflow, flush and async reset.
module tb_reg_scoreboard_dep;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    localparam logic [3:0] F = 4'b1111;

    always #5 clk = ~clk;

    reg_scoreboard_dep_if sb ();

    reg_scoreboard_dep dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        sb.flush       = 1'b0;
        sb.issue_valid = 1'b0;
        sb.src_needed  = '0;
        sb.src_addr    = '0;
        sb.src_strb    = '0;
        sb.dst_ld      = '0;
        sb.dst_addr    = '0;
        sb.dst_strb    = '0;
        sb.wb_valid    = '0;
        sb.wb_addr     = '0;
        sb.wb_strb     = '0;
    endtask

    task automatic src(input int i, input int a, input logic [3:0] s);
        sb.src_needed[i]     = 1'b1;
        sb.src_addr[i*3 +: 3] = 3'(a);
        sb.src_strb[i*4 +: 4] = s;
    endtask

    task automatic dst(input int i, input int a, input logic [3:0] s);
        sb.dst_ld[i]          = 1'b1;
        sb.dst_addr[i*3 +: 3] = 3'(a);
        sb.dst_strb[i*4 +: 4] = s;
    endtask

    task automatic wb(input int i, input int a, input logic [3:0] s);
        sb.wb_valid[i]       = 1'b1;
        sb.wb_addr[i*3 +: 3] = 3'(a);
        sb.wb_strb[i*4 +: 4] = s;
    endtask

    initial begin
        idle();
        #1;
        sb.issue_valid = 1'b1;
        #1;
        chk("rst_stall", sb.stall, 0);
        chk("rst_dep", sb.dep_mask, 0);
        chk("rst_busy", sb.busy, 0);
        chk("rst_err", sb.err_underflow, 0);
        chk("rst_accept", sb.issue_accept, 1);

        // basic RAW hazard on reg 0
        @(negedge clk); rst_n = 1'b1; idle();
        sb.issue_valid = 1'b1; dst(0, 0, F); #1;
        chk("iss0_accept", sb.issue_accept, 1);
        @(negedge clk); idle();
        sb.issue_valid = 1'b1; src(0, 0, 4'b0001); wb(0, 0, F); #1;
        chk("raw_stall_nobypass", sb.stall, 1);
        chk("raw_dep", sb.dep_mask, 4'b0001);
        chk("raw_busy", sb.busy, 1);
        chk("raw_accept", sb.issue_accept, 0);
        @(negedge clk); idle();
        sb.issue_valid = 1'b1; src(0, 0, 4'b0001); #1;
        chk("raw_cleared", sb.stall, 0);
        chk("raw_idle_busy", sb.busy, 0);

        // partial lanes on reg 2
        @(negedge clk); idle();
        sb.issue_valid = 1'b1; dst(0, 2, 4'b0010); #1;
        chk("part_accept", sb.issue_accept, 1);
        @(negedge clk); idle();
        sb.issue_valid = 1'b1; src(0, 2, 4'b0001); #1;
        chk("part_lane0_free", sb.stall, 0);
        src(1, 2, 4'b0011); #1;
        chk("part_lane1_stall", sb.stall, 1);
        chk("part_dep", sb.dep_mask, 4'b0010);
        @(negedge clk); idle();
        wb(0, 2, 4'b0010);

        // saturation on reg 5
        repeat (3) begin
            @(negedge clk); idle();
            sb.issue_valid = 1'b1; dst(0, 5, F); #1;
            chk("sat_accept", sb.issue_accept, 1);
        end
        @(negedge clk); idle();
        sb.issue_valid = 1'b1; dst(0, 5, F); #1;
        chk("sat_full_stall", sb.stall, 1);
        chk("sat_full_dep", sb.dep_mask, 0);
        wb(0, 5, F); #1;
        chk("sat_full_wb_same", sb.stall, 1);
        @(negedge clk); idle();
        sb.issue_valid = 1'b1; dst(0, 5, F); #1;
        chk("sat_4th_accept", sb.issue_accept, 1);
        @(negedge clk); idle(); #1;
        chk("sat_busy", sb.busy, 1);
        wb(0, 5, F); wb(1, 5, F); wb(2, 5, F);
        @(negedge clk); idle(); #1;
        chk("sat_drained", sb.busy, 0);
        chk("sat_no_err", sb.err_underflow, 0);

        // same-cycle issue and writeback on reg 3
        sb.issue_valid = 1'b1; dst(0, 3, F);
        @(negedge clk); idle();
        sb.issue_valid = 1'b1; dst(0, 3, F); wb(0, 3, F); #1;
        chk("same_accept", sb.issue_accept, 1);
        @(negedge clk); idle();
        sb.issue_valid = 1'b1; src(2, 3, 4'b1000); #1;
        chk("same_still_stall", sb.stall, 1);
        chk("same_dep", sb.dep_mask, 4'b0100);
        wb(0, 3, F);
        @(negedge clk); idle(); #1;
        chk("same_drained", sb.busy, 0);

        // underflow on reg 7
        wb(0, 7, F); #1;
        chk("uf_before", sb.err_underflow, 0);
        @(negedge clk); idle(); #1;
        chk("uf_set", sb.err_underflow, 1);
        chk("uf_busy", sb.busy, 0);

        // multiple destination ports
        sb.issue_valid = 1'b1; dst(0, 1, F); dst(1, 1, F); dst(2, 4, F); #1;
        chk("md_accept", sb.issue_accept, 1);
        @(negedge clk); idle();
        sb.issue_valid = 1'b1; src(0, 1, F); #1;
        chk("md_r1_cnt2", sb.stall, 1);
        wb(0, 1, F);
        @(negedge clk); idle();
        sb.issue_valid = 1'b1; src(0, 1, F); #1;
        chk("md_r1_cnt1", sb.stall, 1);
        wb(1, 1, F);
        @(negedge clk); idle();
        sb.issue_valid = 1'b1; src(0, 1, F); #1;
        chk("md_r1_clear", sb.stall, 0);
        src(1, 4, 4'b0100); #1;
        chk("md_r4_dep", sb.dep_mask, 4'b0010);
        wb(2, 4, F);
        @(negedge clk); idle(); #1;
        chk("md_drained", sb.busy, 0);

        // flush with five pending registers
        sb.issue_valid = 1'b1; dst(0, 0, F); dst(1, 1, F); dst(2, 2, F);
        @(negedge clk); idle();
        sb.issue_valid = 1'b1; dst(0, 3, F); dst(1, 4, F); #1;
        chk("fl_accept", sb.issue_accept, 1);
        @(negedge clk); idle(); #1;
        chk("fl_busy_pre", sb.busy, 1);
        sb.flush = 1'b1; sb.issue_valid = 1'b1; dst(0, 6, F);
        @(negedge clk); idle(); #1;
        chk("fl_busy_post", sb.busy, 0);
        chk("fl_err_sticky", sb.err_underflow, 1);
        sb.issue_valid = 1'b1; src(0, 6, F); #1;
        chk("fl_prio", sb.stall, 0);

        // asynchronous reset mid-cycle
        @(negedge clk); idle();
        sb.issue_valid = 1'b1; dst(0, 6, F);
        @(negedge clk); idle();
        sb.issue_valid = 1'b1; src(0, 6, 4'b0001); #1;
        chk("ar_stall_pre", sb.stall, 1);
        chk("ar_busy_pre", sb.busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_stall", sb.stall, 0);
        chk("ar_dep", sb.dep_mask, 0);
        chk("ar_busy", sb.busy, 0);
        chk("ar_accept", sb.issue_accept, 1);
        chk("ar_err", sb.err_underflow, 0);
        @(negedge clk); rst_n = 1'b1; idle(); #1;
        chk("ar_after", sb.busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
